// File: rtl/rv_pkg.sv
// Shared RV32 encodings for writeback select and load funct3, used by decode, MEM and WB.
package rv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned FUNCT3_W   = 3;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_e;

  localparam logic [FUNCT3_W-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: picks byte/half/word from an aligned word and extends it.
module load_align
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]     word_i,
  input  logic [1:0]          off_i,
  input  logic [FUNCT3_W-1:0] funct3_i,
  output logic [XLEN-1:0]     data_c,
  output logic                misaligned_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = 8'h00;
    half_sel     = 16'h0000;
    data_c       = word_i;
    misaligned_c = 1'b0;

    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    // Misaligned halves fall back to the half chosen by off[1]
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_LB:  data_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_c = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data_c       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned_c = off_i[0];
      end
      F3_LHU: begin
        data_c       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned_c = off_i[0];
      end
      F3_LW: begin
        data_c       = word_i;
        misaligned_c = (off_i != 2'd0);
      end
      default: data_c = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures one instruction per cycle, forms the register-file
// write, mirrors it onto the decode bypass and counts retired instructions.
module mem_wb_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  VALID_IN,
  input  logic                  STALL,
  input  logic                  FLUSH,
  input  logic                  REG_WRITE_IN,
  input  logic [REG_ADDR_W-1:0] RD_ADDR_IN,
  input  logic [WB_SEL_W-1:0]   WB_SEL_IN,
  input  logic [FUNCT3_W-1:0]   FUNCT3_IN,
  input  logic [XLEN-1:0]       ALU_RESULT_IN,
  input  logic [XLEN-1:0]       LOAD_WORD_IN,
  input  logic [XLEN-1:0]       PC_PLUS4_IN,
  output logic [XLEN-1:0]       WB_DATA,
  output logic [REG_ADDR_W-1:0] WB_ADDR,
  output logic                  WB_WRITE,
  output logic                  FWD_VALID,
  output logic [REG_ADDR_W-1:0] FWD_ADDR,
  output logic [XLEN-1:0]       FWD_DATA,
  output logic                  MISALIGNED,
  output logic [CNT_W-1:0]      RETIRED
);

  logic                  valid_q,      valid_d;
  logic                  write_q,      write_d;
  logic [REG_ADDR_W-1:0] addr_q,       addr_d;
  logic [XLEN-1:0]       data_q,       data_d;
  logic                  misaligned_q, misaligned_d;
  logic [CNT_W-1:0]      retired_q,    retired_d;

  logic [XLEN-1:0] load_data_c;
  logic            load_mis_c;
  logic            take_c;

  load_align #(.XLEN(XLEN)) u_load_align (
    .word_i       (LOAD_WORD_IN),
    .off_i        (ALU_RESULT_IN[1:0]),
    .funct3_i     (FUNCT3_IN),
    .data_c       (load_data_c),
    .misaligned_c (load_mis_c)
  );

  // Next-state: bubble by default, capture only a clean valid instruction
  always_comb begin
    take_c       = VALID_IN & ~STALL & ~FLUSH;
    valid_d      = 1'b0;
    write_d      = 1'b0;
    addr_d       = '0;
    data_d       = '0;
    misaligned_d = 1'b0;
    retired_d    = retired_q + CNT_W'(valid_q);

    if (take_c) begin
      valid_d = 1'b1;
      addr_d  = RD_ADDR_IN;
      write_d = REG_WRITE_IN & (RD_ADDR_IN != '0);
      case (wb_sel_e'(WB_SEL_IN))
        WB_MEM: begin
          data_d       = load_data_c;
          misaligned_d = load_mis_c;
        end
        WB_PC4:  data_d = PC_PLUS4_IN;
        default: data_d = ALU_RESULT_IN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      misaligned_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      misaligned_q <= misaligned_d;
      retired_q    <= retired_d;
    end
  end

  // Bypass is an exact copy of the pending register-file write
  assign WB_DATA    = data_q;
  assign WB_ADDR    = addr_q;
  assign WB_WRITE   = write_q;
  assign FWD_VALID  = write_q;
  assign FWD_ADDR   = addr_q;
  assign FWD_DATA   = data_q;
  assign MISALIGNED = misaligned_q;
  assign RETIRED    = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver queues expected outputs, monitor pops and compares.
module tb_mem_wb_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            VALID_IN, STALL, FLUSH, REG_WRITE_IN;
  logic [4:0]      RD_ADDR_IN;
  logic [1:0]      WB_SEL_IN;
  logic [2:0]      FUNCT3_IN;
  logic [31:0]     ALU_RESULT_IN, LOAD_WORD_IN, PC_PLUS4_IN;
  logic [31:0]     WB_DATA, FWD_DATA;
  logic [4:0]      WB_ADDR, FWD_ADDR;
  logic            WB_WRITE, FWD_VALID, MISALIGNED;
  logic [CNT_W-1:0] RETIRED;

  mem_wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .VALID_IN(VALID_IN), .STALL(STALL), .FLUSH(FLUSH),
    .REG_WRITE_IN(REG_WRITE_IN), .RD_ADDR_IN(RD_ADDR_IN), .WB_SEL_IN(WB_SEL_IN),
    .FUNCT3_IN(FUNCT3_IN), .ALU_RESULT_IN(ALU_RESULT_IN), .LOAD_WORD_IN(LOAD_WORD_IN),
    .PC_PLUS4_IN(PC_PLUS4_IN), .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR), .WB_WRITE(WB_WRITE),
    .FWD_VALID(FWD_VALID), .FWD_ADDR(FWD_ADDR), .FWD_DATA(FWD_DATA),
    .MISALIGNED(MISALIGNED), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
    logic [3:0]  ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   wr_pulses = 0;
  logic [3:0] exp_ret    = 4'd0;
  logic       prev_valid = 1'b0;

  localparam logic [31:0] LW_WORD = 32'h80FF_7F01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_idle();
    VALID_IN = 0; STALL = 0; FLUSH = 0; REG_WRITE_IN = 0; RD_ADDR_IN = 0;
    WB_SEL_IN = 0; FUNCT3_IN = 0; ALU_RESULT_IN = 0; LOAD_WORD_IN = 0; PC_PLUS4_IN = 0;
  endtask

  // Drive one cycle of MEM-stage inputs and queue the hand-computed result
  task automatic drive(input logic v, input logic st, input logic fl, input logic rw,
                       input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] word, input logic [31:0] pc4,
                       input logic [31:0] exp_d, input logic exp_m);
    exp_t e;
    logic take;
    @(negedge CLK);
    VALID_IN = v; STALL = st; FLUSH = fl; REG_WRITE_IN = rw; RD_ADDR_IN = rd;
    WB_SEL_IN = sel; FUNCT3_IN = f3; ALU_RESULT_IN = alu; LOAD_WORD_IN = word; PC_PLUS4_IN = pc4;
    take   = v & ~st & ~fl;
    e.ret  = exp_ret + 4'(prev_valid);
    exp_ret    = e.ret;
    prev_valid = take;
    e.wr   = take & rw & (rd != 5'd0);
    e.addr = take ? rd : 5'd0;
    e.data = take ? exp_d : 32'd0;
    e.mis  = take & exp_m;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      checks++;
      $display("FAIL drain: %0d entries still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare DUT outputs shortly after each edge against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_write",   32'(WB_WRITE),   32'(e.wr));
        chk("wb_addr",    32'(WB_ADDR),    32'(e.addr));
        chk("wb_data",    WB_DATA,         e.data);
        chk("fwd_valid",  32'(FWD_VALID),  32'(e.wr));
        chk("fwd_addr",   32'(FWD_ADDR),   32'(e.addr));
        chk("fwd_data",   FWD_DATA,        e.data);
        chk("misaligned", 32'(MISALIGNED), 32'(e.mis));
        chk("retired",    32'(RETIRED),    32'(e.ret));
        if (WB_WRITE) wr_pulses++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_pulses;
    set_idle();
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_wb_write", 32'(WB_WRITE), 32'd0);
    chk("rst_wb_data",  WB_DATA,       32'd0);
    chk("rst_retired",  32'(RETIRED),  32'd0);
    RESET = 1'b1;

    repeat (3) idle();

    // ALU op to rd=5, then one idle to see the retire count
    drive(1, 0, 0, 1, 5'd5, 2'b00, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 32'h0000_1234, 1'b0);
    idle();

    // Loads from 0x80FF7F01, back-to-back
    drive(1, 0, 0, 1, 5'd6,  2'b01, 3'b000, 32'h0000_1003, LW_WORD, 32'd0, 32'hFFFF_FF80, 1'b0);
    drive(1, 0, 0, 1, 5'd7,  2'b01, 3'b100, 32'h0000_1003, LW_WORD, 32'd0, 32'h0000_0080, 1'b0);
    drive(1, 0, 0, 1, 5'd8,  2'b01, 3'b001, 32'h0000_1002, LW_WORD, 32'd0, 32'hFFFF_80FF, 1'b0);
    drive(1, 0, 0, 1, 5'd9,  2'b01, 3'b101, 32'h0000_1000, LW_WORD, 32'd0, 32'h0000_7F01, 1'b0);
    drive(1, 0, 0, 1, 5'd10, 2'b01, 3'b010, 32'h0000_1000, LW_WORD, 32'd0, 32'h80FF_7F01, 1'b0);
    drive(1, 0, 0, 1, 5'd11, 2'b01, 3'b001, 32'h0000_1001, LW_WORD, 32'd0, 32'h0000_7F01, 1'b1);
    drive(1, 0, 0, 1, 5'd12, 2'b01, 3'b010, 32'h0000_1002, LW_WORD, 32'd0, 32'h80FF_7F01, 1'b1);
    drive(1, 0, 0, 1, 5'd12, 2'b01, 3'b011, 32'h0000_1001, LW_WORD, 32'd0, 32'h80FF_7F01, 1'b0);

    // x0 destination, non-writing instruction, reserved select
    drive(1, 0, 0, 1, 5'd0,  2'b00, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'hDEAD_BEEF, 1'b0);
    drive(1, 0, 0, 0, 5'd7,  2'b00, 3'd0, 32'h0000_0055, 32'd0, 32'd0, 32'h0000_0055, 1'b0);
    drive(1, 0, 0, 1, 5'd13, 2'b11, 3'd0, 32'h0000_0077, LW_WORD, 32'h200, 32'h0000_0077, 1'b0);

    // Stall, flush, both -> bubbles; then JAL
    drive(1, 1, 0, 1, 5'd3, 2'b00, 3'd0, 32'h1111_1111, 32'd0, 32'd0, 32'h1111_1111, 1'b0);
    drive(1, 0, 1, 1, 5'd3, 2'b00, 3'd0, 32'h2222_2222, 32'd0, 32'd0, 32'h2222_2222, 1'b0);
    drive(1, 1, 1, 1, 5'd3, 2'b01, 3'b001, 32'h0000_0001, LW_WORD, 32'd0, 32'h0000_7F01, 1'b1);
    drive(1, 0, 0, 1, 5'd1, 2'b10, 3'd0, 32'h0000_0050, 32'd0, 32'h0000_0104, 32'h0000_0104, 1'b0);
    // Same rd twice in a row: both writes issued in order
    drive(1, 0, 0, 1, 5'd1, 2'b00, 3'd0, 32'h0000_00AA, 32'd0, 32'd0, 32'h0000_00AA, 1'b0);
    drive(1, 0, 0, 1, 5'd1, 2'b00, 3'd0, 32'h0000_00BB, 32'd0, 32'd0, 32'h0000_00BB, 1'b0);
    idle();

    // Asynchronous reset while an instruction is held
    drive(1, 0, 0, 1, 5'd9, 2'b00, 3'd0, 32'h0000_0999, 32'd0, 32'd0, 32'h0000_0999, 1'b0);
    @(posedge CLK);
    #3;
    set_idle();
    RESET = 1'b0;
    #1;
    chk("async_rst_wb_write", 32'(WB_WRITE),  32'd0);
    chk("async_rst_wb_addr",  32'(WB_ADDR),   32'd0);
    chk("async_rst_wb_data",  WB_DATA,        32'd0);
    chk("async_rst_fwd",      32'(FWD_VALID), 32'd0);
    chk("async_rst_retired",  32'(RETIRED),   32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    exp_ret    = 4'd0;
    prev_valid = 1'b0;
    drain();

    // 17 back-to-back retirements through a 4-bit counter
    start_pulses = wr_pulses;
    for (int i = 0; i < 17; i++)
      drive(1, 0, 0, 1, 5'((i % 31) + 1), 2'b00, 3'd0, 32'(i), 32'd0, 32'd0, 32'(i), 1'b0);
    idle();
    idle();
    drain();
    chk("wrap_retired",   32'(RETIRED), 32'd1);
    chk("wrap_wr_pulses", 32'(wr_pulses - start_pulses), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback mux of the RV32 core; sits directly upstream of the 32x32 register file and drives its write data, write address and write enable.
- Captures one instruction per cycle from the MEM stage and aligns and sign/zero-extends load data.
- Suppresses writes to x0 and to bubbles.
- Exports a bypass copy of the pending write for decode-stage forwarding, because register-file reads are not write-through.
- Counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- CLK in 1: single clock, posedge.
- RESET in 1: asynchronous, active-low reset.
- VALID_IN in 1: MEM stage presents a real instruction this cycle.
- STALL in 1: data cache busy; MEM output not consumable; stage loads a bubble.
- FLUSH in 1: kill the incoming instruction; stage loads a bubble.
- REG_WRITE_IN in 1: instruction writes rd.
- RD_ADDR_IN in 5: destination register.
- WB_SEL_IN in 2: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- FUNCT3_IN in 3: load type. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ALU_RESULT_IN in XLEN: ALU result or load address.
- LOAD_WORD_IN in XLEN: aligned 32-bit word returned by the data cache.
- PC_PLUS4_IN in XLEN: link value.
- WB_DATA out XLEN: to register file IN.
- WB_ADDR out 5: to register file INADDRESS.
- WB_WRITE out 1: to register file WRITE.
- FWD_VALID out 1: bypass entry is live; equals WB_WRITE.
- FWD_ADDR out 5: equals WB_ADDR.
- FWD_DATA out XLEN: equals WB_DATA.
- MISALIGNED out 1: registered flag; the held load is misaligned.
- RETIRED out CNT_W: count of valid instructions that left the stage.

Behaviour:
- Reset (RESET=0, asynchronous):
  - stage register loads a bubble: valid=0, rd=0, data=0.
  - WB_WRITE=0, WB_ADDR=0, WB_DATA=0, FWD_*=0, MISALIGNED=0, RETIRED=0.
  - Reset mid-stream discards the held instruction; no write is issued for it.
- Capture, each posedge CLK with RESET=1:
  - If FLUSH or STALL or !VALID_IN: load a bubble. FLUSH has priority over STALL; both give a bubble.
  - Otherwise capture the instruction and compute the write-back value in the same edge. Outputs are registered and there is no combinational path from inputs to outputs.
- Latency:
  - Instruction presented before edge N gives WB_* valid during cycle N.
  - The register file commits at edge N+1.
  - Each instruction is held for exactly one cycle, so WB_WRITE is a single-cycle pulse per instruction and never repeats.
- Write enable: WB_WRITE = valid & REG_WRITE & (rd != 0).
  - A bubble or x0 destination gives WB_WRITE=0.
  - WB_ADDR and WB_DATA still reflect the captured values when valid, and are 0 for a bubble.
- Load alignment uses off = ALU_RESULT_IN[1:0].
  - Byte: LOAD_WORD_IN[8*off +: 8]. LB sign-extends; LBU zero-extends.
  - Half: off[1] selects the upper or lower 16 bits. LH sign-extends; LHU zero-extends.
  - LW: whole word.
  - Undefined funct3 returns the whole word.
- Misalignment:
  - Defined as half with off[0]=1, or word with off!=0.
  - Sets MISALIGNED=1 for that one cycle.
  - Data uses the truncated alignment above: half uses off[1]; word ignores off.
  - The write still occurs; the trap is handled elsewhere.
- Writeback select: 00 and 11 give ALU_RESULT_IN; 01 gives aligned load; 10 gives PC_PLUS4_IN.
- Forwarding: FWD_* mirror WB_* exactly. Decode must prefer FWD_DATA when FWD_VALID and FWD_ADDR matches and is nonzero.
- RETIRED:
  - Increments by 1 on every edge where the held entry is valid, including x0 and non-writing instructions.
  - Wraps modulo 2^CNT_W with no saturation.
  - Unaffected by STALL or FLUSH except that bubbles do not count.
- Back-to-back writes to the same rd are issued in order, one per cycle. No merging.

Decomposition:
- Shared package rv_pkg holds the WB_SEL encodings (WB_ALU, WB_MEM, WB_PC4) and the FUNCT3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU). The same encodings are used by the decoder and the MEM stage.
- One natural sub-module: load_align. It is purely combinational (word, offset, funct3 in; aligned data and misaligned flag out) and is reused by the MEM stage for store-data checks.

Test Plan:
- Reset, then RESET=1 with no VALID_IN for 3 cycles -> WB_WRITE=0, WB_DATA=0, RETIRED=0 throughout; assert RESET=0 asynchronously mid-cycle -> outputs clear before the next edge.
- ALU op: rd=5, WB_SEL=00, ALU=0x0000_1234 -> next cycle WB_WRITE=1, WB_ADDR=5, WB_DATA=0x1234, FWD mirrors; the following cycle WB_WRITE=0, RETIRED=1.
- Loads with word 0x80FF_7F01:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
  - LH off=1 -> MISALIGNED=1 and data 0x0000_7F01.
- rd=0 with REG_WRITE=1, ALU=0xDEAD_BEEF -> WB_WRITE=0, FWD_VALID=0, RETIRED still increments.
- VALID_IN with STALL=1, then the same with FLUSH=1, then FLUSH=1 and STALL=1 -> a bubble each cycle: no WB_WRITE, no RETIRED increment. The next clean instruction (JAL rd=1, WB_SEL=10, PC+4=0x104) -> WB_DATA=0x104, WB_WRITE=1.
- Preload RETIRED near wrap by forcing CNT_W=4 and retiring 17 valid instructions back-to-back -> RETIRED=1, and WB_WRITE pulses exactly 17 times for the non-x0 rds.
